// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered RV immediate generator with valid/ready output stage and flush
module imm_gen_stage #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 32,
    parameter int EXT_SRC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [2:0]       in_immsrc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_U     = 3'd0;
    localparam logic [2:0] FMT_J     = 3'd1;
    localparam logic [2:0] FMT_I     = 3'd2;
    localparam logic [2:0] FMT_SHIFT = 3'd3;
    localparam logic [2:0] FMT_LOAD  = 3'd4;
    localparam logic [2:0] FMT_S     = 3'd5;
    localparam logic [2:0] FMT_B     = 3'd6;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    logic [2:0]      w_dec_fmt;
    logic            w_dec_illegal;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_capture;

    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_fmt;
    logic [TAG_W-1:0] r_tag;
    logic            r_illegal;

    always_comb begin
        w_dec_fmt     = FMT_NONE;
        w_dec_illegal = 1'b0;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: w_dec_fmt = FMT_U;
            7'b1101111:             w_dec_fmt = FMT_J;
            7'b0010011:             w_dec_fmt = (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
                                                ? FMT_SHIFT : FMT_I;
            7'b0000011, 7'b1100111: w_dec_fmt = FMT_LOAD;
            7'b0100011:             w_dec_fmt = FMT_S;
            7'b1100011:             w_dec_fmt = FMT_B;
            7'b0110011:             w_dec_fmt = FMT_NONE;
            default:                w_dec_illegal = 1'b1;
        endcase
    end

    assign w_fmt     = (EXT_SRC != 0) ? in_immsrc : w_dec_fmt;
    assign w_illegal = (EXT_SRC != 0) ? 1'b0 : w_dec_illegal;

    // Build a 32-bit immediate first; every format sign-extends from bit 31 except shift, whose bit 31 is 0.
    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FMT_U:            w_imm32 = {in_instr[31:12], 12'd0};
            FMT_J:            w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            FMT_I, FMT_LOAD:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_SHIFT:        w_imm32 = (XLEN == 64) ? {26'd0, in_instr[25:20]} : {27'd0, in_instr[24:20]};
            FMT_S:            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:            w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            default:          w_imm32 = 32'd0;
        endcase
    end

    assign w_imm     = XLEN'($signed(w_imm32));
    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_imm     <= '0;
            r_fmt     <= 3'd0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_capture) begin
                r_imm     <= w_imm;
                r_fmt     <= w_fmt;
                r_tag     <= in_tag;
                r_illegal <= w_illegal;
            end
            // Flush wins over a same-cycle capture; data may still load but is hidden.
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_imm     = r_imm;
    assign out_fmt     = r_fmt;
    assign out_tag     = r_tag;
    assign out_illegal = r_illegal;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Takes a full 32-bit RV instruction plus a tag (PC), decodes the immediate format from the opcode, and builds the sign-extended XLEN-bit immediate.
- Flags illegal opcodes and presents the result through a one-entry valid/ready pipeline register with flush.
- Sits between fetch and decode/execute in the pipelined core.

Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- TAG_W, 32, width of the pass-through tag (PC).
- EXT_SRC, 0, 1 = use the in_immsrc port instead of opcode decode.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  stage can accept an input this cycle.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  tag/PC carried alongside the instruction.
- in_immsrc  in  3  external format code; used only when EXT_SRC=1.
- flush  in  1  kill the held entry.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format code used.
- out_tag  out  TAG_W  registered tag.
- out_illegal  out  1  opcode not recognised.

Behaviour:
- Format codes:
  - 0 = U (LUI 0110111, AUIPC 0010111)
  - 1 = J (1101111)
  - 2 = I-ALU (0010011, funct3 not 001/101)
  - 3 = shift-immediate (0010011, funct3 001 or 101)
  - 4 = I-load/JALR (0000011, 1100111)
  - 5 = S (0100011)
  - 6 = B (1100011)
  - 7 = none (0110011 R-type; immediate 0)
- Any other opcode decodes to fmt 7, imm 0, illegal=1.
- With EXT_SRC=1, fmt = in_immsrc and illegal is always 0.
- Immediate construction (s = instr[31], sign-extended to XLEN):
  - U: instr[31:12] followed by 12 zeros, then sign-extended.
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}.
  - I-ALU and I-load/JALR: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}.
  - Shift: zero-extended instr[24:20] when XLEN=32; zero-extended instr[25:20] when XLEN=64.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An entry is captured when in_valid && in_ready. Latency is exactly 1 cycle from capture to out_valid.
  - Output registers hold steady while out_valid && !out_ready.
  - A capture and an output consume in the same cycle give back-to-back throughput of 1 per cycle.
  - out_valid drops when the entry is consumed and no new capture occurs.
- Flush:
  - On the next edge, out_valid=0.
  - Flush overrides a same-cycle capture; the input is dropped even though in_ready was 1.
  - Data registers may update; their value is don't-care while out_valid=0.
- Reset (rst_n=0 at a clock edge):
  - out_valid, out_imm, out_fmt, out_tag and out_illegal all go to 0.
  - Reset overrides flush and capture.
  - Mid-stream reset discards the held entry.
- Synthesis-time check: XLEN must be 32 or 64.

Test Plan:
- LUI 0x12345237, XLEN=32 -> after 1 cycle: out_valid=1, out_imm=0x12345000, fmt=0, illegal=0.
- ADDI 0xFFF00093 -> out_imm=0xFFFFFFFF, fmt=2. Same instruction with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFF.
- Branch, jump and shift decode:
  - BEQ 0xFE000EE3 -> out_imm=0xFFFFFFFC, fmt=6.
  - JAL 0x0080006F -> out_imm=0x8, fmt=1.
  - SRAI 0x4030D093 -> out_imm=0x3, fmt=3.
- Backpressure:
  - Stream 4 instructions with out_ready=0 for 3 cycles -> in_ready=0, and the first entry is held stable.
  - Then set out_ready=1 -> entries drain in order, one per cycle, with matching tags.
- Flush and illegal opcode:
  - flush asserted with in_valid=1 -> next cycle out_valid=0, and that input never appears.
  - Opcode 0x7F -> illegal=1, imm=0, fmt=7.
- Reset and external source:
  - rst_n=0 while out_valid=1 -> next cycle all outputs 0.
  - EXT_SRC=1, in_immsrc=5, instr 0xFE112E23 -> out_imm=0xFFFFFFFC, fmt=5.
